irq_arbiter: RTL
================

IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles a button level needs before it is accepted (used only with IRQ_DEBOUNCE_EN).
REQ-002 clk  in  1  single clock, all state on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 but  in  5  raw buttons: [4]=c, [3]=u, [2]=d, [1]=l, [0]=r.
REQ-005 ebreak  in  1  one-cycle breakpoint pulse from decode.
REQ-006 error  in  4  CPU error code: 0=none, 1=div-by-0, 2=mem-access, 3=opcode.
REQ-007 if_pc, id_pc  in  32  PCs of the IF and ID stages.
REQ-008 use_if_pc  in  1  when 1, the button return PC is if_pc; otherwise it is id_pc.
REQ-009 irq_valid  out  1  an interrupt is offered to the pipeline controller.
REQ-010 irq_ready  in  1  the pipeline controller accepts the offer.
REQ-011 irq_vec, irq_cause, irq_epc, irq_bs  out  32 each  vector, mcause, return PC and button code of the offer.
REQ-012 irq_done  in  1  handler finished (mipd written to 1).
REQ-013 busy  out  1  state is not IDLE.
REQ-014 pending  out  3  sticky pending flags: [2]=error, [1]=button, [0]=ebreak.

Function
REQ-015 Buttons shall pass through a 2-flop synchronizer; a button event is the rising edge of the OR of all 5 synchronized bits.
REQ-016 A button event shall set pending[1] and latch a code with priority u=1 > d=2 > l=3 > r=4 > c=5, plus the return PC selected by use_if_pc.
REQ-017 A cycle with error!=0 shall set pending[2] and latch the code and id_pc, unless pending[2] is already set; the first error is kept.
REQ-018 ebreak=1 shall set pending[0] and latch id_pc.
REQ-019 States: IDLE, OFFER, SERVICE.
REQ-020 IDLE: if any pending bit is set, select the highest-priority class (error > button > ebreak), load the irq_* registers and go to OFFER.
REQ-021 irq_valid=1 exactly while in OFFER; irq_* values stay stable until the handshake completes.
REQ-022 In OFFER, irq_valid & irq_ready in the same cycle shall clear the served pending bit and go to SERVICE.
REQ-023 In SERVICE, irq_done shall return the block to IDLE; the earliest next offer is 2 cycles after irq_done.
REQ-024 irq_done outside SERVICE shall be ignored.
REQ-025 Payloads:
- error div-by-0: vec=0xF008, cause=3.
- error mem-access: vec=0xF008, cause=4.
- error opcode: vec=0xF008, cause=5.
- In all three error cases: epc=latched PC, bs=0.
- button: vec=0xF010, cause=6, epc=latched PC, bs=code.
- ebreak: vec=0xF000, cause=1, epc=latched PC, bs=0.
REQ-026 New events arriving while busy shall set their pending bits and not disturb the current offer.
REQ-027 If an event sets a pending bit in the same cycle that bit is cleared by a handshake, the set wins and the new payload is latched.
REQ-028 A repeat event of an already-pending class (button or ebreak) shall overwrite that class's latched payload (last wins).

Reset
REQ-029 While rst=1: state=IDLE; irq_valid=0, busy=0, pending=0; all irq_* outputs = 0; synchronizer and debounce registers = 0.
REQ-030 rst asserted mid-OFFER or mid-SERVICE shall abort immediately with no handshake.
REQ-031 After rst is released, the first offer shall occur no earlier than 2 cycles after a new event.

Configuration
REQ-032 With IRQ_DEBOUNCE_EN defined, each synchronized button shall pass through a counter and change its filtered level only after DEB_CYCLES consecutive equal samples.
REQ-033 With IRQ_DEBOUNCE_EN defined, the REQ-015 edge detection shall run on the filtered levels.
REQ-034 Without IRQ_DEBOUNCE_EN, no counters shall exist and edge detection shall run on the synchronized levels directly.

Verification
REQ-035 ebreak pulse with id_pc=0x40, irq_ready=1 -> irq_valid asserted with vec=0xF000, cause=1, epc=0x40; after irq_done, busy=0.
REQ-036 error=1 and ebreak in the same cycle, id_pc=0x80 -> first offer is cause=3, vec=0xF008; after irq_done, the ebreak offer follows (cause=1, epc=0x80).
REQ-037 but[3] held high, use_if_pc=1, if_pc=0x100, irq_ready=0 for 5 cycles -> irq_valid stays 1 with payload stable (cause=6, bs=1, epc=0x100); handshake on cycle 6.
REQ-038 Button edge during SERVICE of an ebreak -> pending=3'b010 and irq_valid=0 until irq_done; then a button offer is made.
REQ-039 rst pulsed during OFFER -> next cycle irq_valid=0, pending=0, all irq_* outputs=0.
REQ-040 With IRQ_DEBOUNCE_EN and DEB_CYCLES=16: a 10-cycle glitch on but[0] -> no event; a 20-cycle press -> a single offer with bs=4.

Source files
------------

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - interrupt arbiter for error, button and ebreak sources (optional IRQ_DEBOUNCE_EN)
module irq_arbiter #(
    parameter int DEB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  but,
    input  logic        ebreak,
    input  logic [3:0]  error,
    input  logic [31:0] if_pc,
    input  logic [31:0] id_pc,
    input  logic        use_if_pc,
    output logic        irq_valid,
    input  logic        irq_ready,
    output logic [31:0] irq_vec,
    output logic [31:0] irq_cause,
    output logic [31:0] irq_epc,
    output logic [31:0] irq_bs,
    input  logic        irq_done,
    output logic        busy,
    output logic [2:0]  pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Class index doubles as the pending bit position.
    localparam logic [1:0] CL_EBREAK = 2'd0;
    localparam logic [1:0] CL_BUTTON = 2'd1;
    localparam logic [1:0] CL_ERROR  = 2'd2;

    logic [4:0] sync1_q, sync2_q;
    logic [4:0] btn_lvl;

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= but;
            sync2_q <= sync1_q;
        end
    end

`ifdef IRQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];
    logic [4:0]    filt_q, filt_d;

    // Per-button counter: runs while the synchronized level differs from the filtered one.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign btn_lvl = filt_q;
`else
    assign btn_lvl = sync2_q;
`endif

    logic       btn_or_q;
    logic       btn_evt;
    logic [2:0] btn_code;

    assign btn_evt = (|btn_lvl) & ~btn_or_q;

    // Button code with priority u > d > l > r > c.
    always_comb begin
        btn_code = 3'd0;
        if (btn_lvl[3])      btn_code = 3'd1;
        else if (btn_lvl[2]) btn_code = 3'd2;
        else if (btn_lvl[1]) btn_code = 3'd3;
        else if (btn_lvl[0]) btn_code = 3'd4;
        else if (btn_lvl[4]) btn_code = 3'd5;
    end

    state_t      state_q, state_d;
    logic [1:0]  served_q, served_d;
    logic        irq_valid_q, irq_valid_d;
    logic        busy_q, busy_d;
    logic [31:0] vec_q, vec_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] bs_q, bs_d;

    logic [2:0]  pend_q, pend_d;
    logic [2:0]  clr;
    logic        err_set;
    logic [3:0]  err_code_q, err_code_d;
    logic [31:0] err_pc_q, err_pc_d;
    logic [2:0]  btn_code_q, btn_code_d;
    logic [31:0] btn_pc_q, btn_pc_d;
    logic [31:0] ebk_pc_q, ebk_pc_d;

    // Handshake clears the served class; a same-cycle set re-arms it and the error slot reopens.
    always_comb begin
        clr = 3'b000;
        if (state_q == ST_OFFER && irq_ready) begin
            clr[served_q] = 1'b1;
        end
        err_set    = (error != 4'd0) && (!pend_q[CL_ERROR] || clr[CL_ERROR]);
        pend_d     = (pend_q & ~clr) | {err_set, btn_evt, ebreak};
        err_code_d = err_set ? error : err_code_q;
        err_pc_d   = err_set ? id_pc : err_pc_q;
        btn_code_d = btn_evt ? btn_code : btn_code_q;
        btn_pc_d   = btn_evt ? (use_if_pc ? if_pc : id_pc) : btn_pc_q;
        ebk_pc_d   = ebreak ? id_pc : ebk_pc_q;
    end

    // Sticky pending flags, latched payloads and button edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            err_code_q <= '0;
            err_pc_q   <= '0;
            btn_code_q <= '0;
            btn_pc_q   <= '0;
            ebk_pc_q   <= '0;
            btn_or_q   <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            err_code_q <= err_code_d;
            err_pc_q   <= err_pc_d;
            btn_code_q <= btn_code_d;
            btn_pc_q   <= btn_pc_d;
            ebk_pc_q   <= ebk_pc_d;
            btn_or_q   <= |btn_lvl;
        end
    end

    // Next state and offer payload; payload only changes when an offer is loaded in IDLE.
    always_comb begin
        state_d     = state_q;
        served_d    = served_q;
        irq_valid_d = irq_valid_q;
        busy_d      = busy_q;
        vec_d       = vec_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        bs_d        = bs_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q[CL_ERROR]) begin
                    served_d = CL_ERROR;
                    vec_d    = 32'h0000_F008;
                    // Codes beyond the defined three are reported as an opcode fault.
                    case (err_code_q)
                        4'd1:    cause_d = 32'd3;
                        4'd2:    cause_d = 32'd4;
                        default: cause_d = 32'd5;
                    endcase
                    epc_d    = err_pc_q;
                    bs_d     = 32'd0;
                end else if (pend_q[CL_BUTTON]) begin
                    served_d = CL_BUTTON;
                    vec_d    = 32'h0000_F010;
                    cause_d  = 32'd6;
                    epc_d    = btn_pc_q;
                    bs_d     = {29'd0, btn_code_q};
                end else begin
                    served_d = CL_EBREAK;
                    vec_d    = 32'h0000_F000;
                    cause_d  = 32'd1;
                    epc_d    = ebk_pc_q;
                    bs_d     = 32'd0;
                end
                if (pend_q != 3'b000) begin
                    state_d     = ST_OFFER;
                    irq_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    served_d = served_q;
                    vec_d    = vec_q;
                    cause_d  = cause_q;
                    epc_d    = epc_q;
                    bs_d     = bs_q;
                end
            end
            ST_OFFER: begin
                if (irq_ready) begin
                    state_d     = ST_SERVICE;
                    irq_valid_d = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                irq_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Arbiter FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            served_q    <= CL_EBREAK;
            irq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            vec_q       <= '0;
            cause_q     <= '0;
            epc_q       <= '0;
            bs_q        <= '0;
        end else begin
            state_q     <= state_d;
            served_q    <= served_d;
            irq_valid_q <= irq_valid_d;
            busy_q      <= busy_d;
            vec_q       <= vec_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            bs_q        <= bs_d;
        end
    end

    assign irq_valid = irq_valid_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign irq_vec   = vec_q;
    assign irq_cause = cause_q;
    assign irq_epc   = epc_q;
    assign irq_bs    = bs_q;

endmodule
